// File: rtl/ring_drain_ctrl.sv
// ring_drain_ctrl: drains an upstream ring buffer into a 2-entry output skid
// (head/tail). It issues reads whenever the skid has room and presents the
// head token to a downstream consumer that may apply back-pressure (I_Nack).
//
// Optional feature: define RING_DRAIN_CNT_EN to build the delivered-token
// counter on O_Cnt. When it is undefined, O_Cnt is tied to 0 and I_CntClr
// is ignored.
module ring_drain_ctrl #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_CNT  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Empty,
  output logic                  O_Re,
  input  logic [WIDTH_DATA-1:0] I_Data,
  output logic                  O_Valid,
  output logic [WIDTH_DATA-1:0] O_Data,
  input  logic                  I_Nack,
  input  logic                  I_Flush,
  input  logic                  I_CntClr,
  output logic [WIDTH_CNT-1:0]  O_Cnt
);

  // Skid occupancy: nothing held, head only, head and tail.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH_DATA-1:0] r_head;
  logic [WIDTH_DATA-1:0] r_tail;
  logic [WIDTH_DATA-1:0] w_head_next;
  logic [WIDTH_DATA-1:0] w_tail_next;
  logic                  w_rd;
  logic                  w_valid;
  logic                  w_xfer;

  // A read is only issued when the skid can accept a token this cycle.
  // Reset and flush both suppress it so nothing is pulled that would be lost.
  assign w_rd    = ~I_Empty & (r_state != S_TWO) & ~I_Flush & ~reset;
  assign w_valid = (r_state != S_EMPTY) & ~reset;
  // Back-pressure only matters while a token is actually being offered.
  assign w_xfer  = w_valid & ~I_Nack;

  assign O_Re    = w_rd;
  assign O_Valid = w_valid;
  assign O_Data  = w_valid ? r_head : '0;

  // State and skid registers; reset empties the skid and clears its storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_next;
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
    end
  end

  // Next-state and skid update: flush wins over everything, otherwise the
  // head always holds the oldest token so order is preserved.
  always_comb begin
    w_state_next = r_state;
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    if (I_Flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_rd) begin
            w_state_next = S_ONE;
            w_head_next  = I_Data;
          end
        end
        S_ONE: begin
          if (w_rd && w_xfer) begin
            // Head leaves as the new token arrives: replace it in place.
            w_head_next = I_Data;
          end else if (w_rd) begin
            w_state_next = S_TWO;
            w_tail_next  = I_Data;
          end else if (w_xfer) begin
            w_state_next = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_xfer) begin
            w_state_next = S_ONE;
            w_head_next  = r_tail;
          end
        end
        default: begin
          w_state_next = S_EMPTY;
        end
      endcase
    end
  end

`ifdef RING_DRAIN_CNT_EN
  logic [WIDTH_CNT-1:0] r_cnt;

  // Delivered-token counter: clear beats increment; flushed cycles do not count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (I_CntClr) begin
      r_cnt <= '0;
    end else if (w_xfer && !I_Flush) begin
      r_cnt <= r_cnt + {{(WIDTH_CNT-1){1'b0}}, 1'b1};
    end
  end

  assign O_Cnt = r_cnt;
`else
  logic w_unused_cntclr;

  assign w_unused_cntclr = I_CntClr;
  assign O_Cnt           = '0;
`endif

endmodule

// File: tb/tb_ring_drain_ctrl.sv
// Directed testbench for ring_drain_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 ns later, and the design updates on the rising edge.
// Counter expectations follow RING_DRAIN_CNT_EN (counter built or tied to 0).
module tb_ring_drain_ctrl;

  localparam int WD = 32;
  localparam int WC = 4;
`ifdef RING_DRAIN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          I_Empty;
  logic          O_Re;
  logic [WD-1:0] I_Data;
  logic          O_Valid;
  logic [WD-1:0] O_Data;
  logic          I_Nack;
  logic          I_Flush;
  logic          I_CntClr;
  logic [WC-1:0] O_Cnt;

  int checks;
  int errors;

  ring_drain_ctrl #(.WIDTH_DATA(WD), .WIDTH_CNT(WC)) dut (
    .clock   (clock),
    .reset   (reset),
    .I_Empty (I_Empty),
    .O_Re    (O_Re),
    .I_Data  (I_Data),
    .O_Valid (O_Valid),
    .O_Data  (O_Data),
    .I_Nack  (I_Nack),
    .I_Flush (I_Flush),
    .I_CntClr(I_CntClr),
    .O_Cnt   (O_Cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of inputs at the falling edge; outputs settle 1 ns later.
  task automatic set_in(input logic rst, input logic emp, input logic [WD-1:0] d,
                        input logic nk, input logic fl, input logic cc);
    @(negedge clock);
    reset    = rst;
    I_Empty  = emp;
    I_Data   = d;
    I_Nack   = nk;
    I_Flush  = fl;
    I_CntClr = cc;
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b want 0", O_Re); end
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", O_Valid); end
    checks++;
    if (O_Data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", O_Data); end
    checks++;
    if (O_Cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", O_Cnt); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL reset_post_valid: got %b want 0", O_Valid); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 1'b0, WD'(k + 1), 1'b0, 1'b0, 1'b0);
      checks++;
      if (O_Re !== 1'b1) begin errors++; $display("FAIL stream_re[%0d]: got %b want 1", k, O_Re); end
      checks++;
      if (O_Valid !== (k > 0)) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", k, O_Valid, (k > 0)); end
      checks++;
      if (O_Data !== WD'(k)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, O_Data, WD'(k)); end
    end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b1 || O_Data !== 32'd8) begin errors++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=8", O_Valid, O_Data); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", O_Valid); end
    $display("test_stream done: 8 tokens");
  endtask

  task automatic test_empty_source();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 32'hFFFF_FFFF, k[0], 1'b0, 1'b0);
      checks++;
      if (O_Re !== 1'b0 || O_Valid !== 1'b0 || O_Data !== '0) begin
        errors++;
        $display("FAIL empty_src[%0d]: got re=%b v=%b d=%h want 0 0 0", k, O_Re, O_Valid, O_Data);
      end
    end
    $display("test_empty_source done");
  endtask

  task automatic test_backpressure();
    set_in(1'b0, 1'b0, 32'hA, 1'b1, 1'b0, 1'b0);
    checks++;
    if (O_Re !== 1'b1) begin errors++; $display("FAIL bp_read_a: got %b want 1", O_Re); end
    set_in(1'b0, 1'b0, 32'hB, 1'b1, 1'b0, 1'b0);
    checks++;
    if (O_Re !== 1'b1 || O_Valid !== 1'b1 || O_Data !== 32'hA) begin
      errors++; $display("FAIL bp_one: got re=%b v=%b d=%h want 1 1 a", O_Re, O_Valid, O_Data);
    end
    set_in(1'b0, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0);
    checks++;
    if (O_Re !== 1'b0) begin errors++; $display("FAIL bp_two_re: got %b want 0", O_Re); end
    checks++;
    if (O_Data !== 32'hA) begin errors++; $display("FAIL bp_two_hold: got %h want a", O_Data); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b1 || O_Data !== 32'hA) begin errors++; $display("FAIL bp_out_a: got v=%b d=%h want 1 a", O_Valid, O_Data); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b1 || O_Data !== 32'hB) begin errors++; $display("FAIL bp_out_b: got v=%b d=%h want 1 b", O_Valid, O_Data); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", O_Valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    set_in(1'b0, 1'b0, 32'h11, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 32'h22, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 32'h99, 1'b0, 1'b1, 1'b0);
    checks++;
    if (O_Re !== 1'b0) begin errors++; $display("FAIL flush_re: got %b want 0", O_Re); end
    checks++;
    if (O_Valid !== 1'b1 || O_Data !== 32'h11) begin errors++; $display("FAIL flush_pre: got v=%b d=%h want 1 11", O_Valid, O_Data); end
    set_in(1'b0, 1'b0, 32'h33, 1'b1, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", O_Valid); end
    checks++;
    if (O_Re !== 1'b1) begin errors++; $display("FAIL flush_reread: got %b want 1", O_Re); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b1 || O_Data !== 32'h33) begin errors++; $display("FAIL flush_first: got v=%b d=%h want 1 33", O_Valid, O_Data); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL flush_drained: got %b want 0", O_Valid); end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, 1'b0, 32'h55, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 32'h66, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Re !== 1'b0 || O_Valid !== 1'b0 || O_Data !== '0) begin
      errors++; $display("FAIL rstmid_during: got re=%b v=%b d=%h want 0 0 0", O_Re, O_Valid, O_Data);
    end
    set_in(1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", O_Valid); end
    checks++;
    if (O_Cnt !== '0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", O_Cnt); end
    checks++;
    if (O_Re !== 1'b1) begin errors++; $display("FAIL rstmid_re: got %b want 1", O_Re); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b1 || O_Data !== 32'h44) begin errors++; $display("FAIL rstmid_resume: got v=%b d=%h want 1 44", O_Valid, O_Data); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_drained: got %b want 0", O_Valid); end
    $display("test_reset_mid done");
  endtask

  // Irregular back-pressure against a small occupancy/queue model of the skid.
  task automatic test_nack_pattern();
    logic [19:0]   nack_pat;
    logic [WD-1:0] q[$];
    logic          exp_re;
    logic          emp;
    logic [WD-1:0] exp_data;
    nack_pat = 20'b0000_0010_1101_1001_0110;
    for (int k = 0; k < 20; k++) begin
      emp = (k >= 12);
      set_in(1'b0, emp, WD'(32'h100 + k), nack_pat[k], 1'b0, 1'b0);
      exp_re   = !emp && (q.size() < 2);
      exp_data = (q.size() > 0) ? q[0] : '0;
      checks++;
      if (O_Re !== exp_re) begin errors++; $display("FAIL pat_re[%0d]: got %b want %b", k, O_Re, exp_re); end
      checks++;
      if (O_Valid !== (q.size() > 0) || O_Data !== exp_data) begin
        errors++; $display("FAIL pat_out[%0d]: got v=%b d=%h want v=%b d=%h", k, O_Valid, O_Data, (q.size() > 0), exp_data);
      end
      if (q.size() > 0 && !nack_pat[k]) begin
        $display("pat deliver %h", exp_data);
        void'(q.pop_front());
      end
      if (exp_re) q.push_back(WD'(32'h100 + k));
    end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL pat_drained: got v=%b left=%0d want 0 0", O_Valid, q.size()); end
    $display("test_nack_pattern done");
  endtask

  task automatic test_counter();
    logic [WC-1:0] exp_cnt;
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Cnt !== '0) begin errors++; $display("FAIL cnt_clr_idle: got %0d want 0", O_Cnt); end
    for (int k = 0; k < 17; k++) set_in(1'b0, 1'b0, WD'(k + 1), 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 32'h5, 1'b0, 1'b0, 1'b0);
    exp_cnt = CNT_EN ? WC'(1) : WC'(0);
    checks++;
    if (O_Cnt !== exp_cnt) begin errors++; $display("FAIL cnt_wrap17: got %0d want %0d", O_Cnt, exp_cnt); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (O_Valid !== 1'b1 || O_Data !== 32'h5) begin errors++; $display("FAIL cnt_clr_xfer_out: got v=%b d=%h want 1 5", O_Valid, O_Data); end
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_Cnt !== '0) begin errors++; $display("FAIL cnt_clr_prio: got %0d want 0", O_Cnt); end
    $display("test_counter done (counter built=%0d)", CNT_EN);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    I_Empty  = 1'b1;
    I_Data   = '0;
    I_Nack   = 1'b0;
    I_Flush  = 1'b0;
    I_CntClr = 1'b0;
    test_reset();
    test_stream();
    test_empty_source();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_nack_pattern();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
